dart_hit_capture: RTL

//  Front-end stage that sits directly upstream of the dart game controller and drives its dart_come / position inputs.

---
 rtl/dart_hit_capture.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dart_hit_capture.sv
// dart_hit_capture
//   Front end for the dart game controller. Synchronises the raw board strobe
//   and coordinate bus, debounces the strobe, and range-checks the coordinates.
//   It then issues one clean dart_come_o pulse per physical hit. Each hit is
//   followed by a lockout window. Capture is suppressed while game_set_i is high.
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   board_hit_i         raw sensor strobe (asynchronous to clk)
//   board_x_i/_y_i      raw coordinates, meaningful while the strobe is high
//   game_set_i          game-over flag, synchronous to clk
//   dart_come_o         1-cycle pulse, valid dart accepted
//   dart_position_x/y_o last accepted coordinates, held until the next accept
//   invalid_o           1-cycle pulse, debounced hit was off-board
//   glitch_o            1-cycle pulse, strobe dropped before debounce completed
//   busy_o              FSM not in IDLE
//   dart_count_o        accepted darts since game_set_i, wraps
module dart_hit_capture #(
   parameter int unsigned DEBOUNCE_CYC = 4,
   parameter int unsigned LOCKOUT_CYC  = 8,
   parameter int unsigned MAX_COORD    = 9,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             board_hit_i,
   input  logic [3:0]       board_x_i,
   input  logic [3:0]       board_y_i,
   input  logic             game_set_i,
   output logic             dart_come_o,
   output logic [3:0]       dart_position_x_o,
   output logic [3:0]       dart_position_y_o,
   output logic             invalid_o,
   output logic             glitch_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] dart_count_o
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, LOCKOUT} state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LOCKOUT_CYC - 1);

   state_t           state, state_nxt;
   logic             hit_m, hit_s, hit_s_d;
   logic [3:0]       x_m, x_s, y_m, y_s;
   logic [1:0]       rdy_pipe;
   logic             armed;
   logic [3:0]       x_l, y_l, x_l_nxt, y_l_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             come_nxt, inv_nxt, glitch_nxt;
   logic             coord_ok;

   // Two-flop synchronisers plus the delayed copy used for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_m   <= 1'b0;
         hit_s   <= 1'b0;
         hit_s_d <= 1'b0;
         x_m     <= '0;
         x_s     <= '0;
         y_m     <= '0;
         y_s     <= '0;
      end else begin
         hit_m   <= board_hit_i;
         hit_s   <= hit_m;
         hit_s_d <= hit_s;
         x_m     <= board_x_i;
         x_s     <= x_m;
         y_m     <= board_y_i;
         y_s     <= y_m;
      end
   end

   // The synchroniser holds reset zeros for two cycles after release. A strobe
   // already high at release would look like a rising edge. Capture is armed
   // only once a genuine post-reset low has been observed on hit_s.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_pipe <= '0;
         armed    <= 1'b0;
      end else begin
         rdy_pipe <= {rdy_pipe[0], 1'b1};
         armed    <= armed | (rdy_pipe[1] & ~hit_s);
      end
   end

   assign coord_ok = (32'(x_l) <= MAX_COORD) && (32'(y_l) <= MAX_COORD);

   always_comb begin
      state_nxt  = state;
      x_l_nxt    = x_l;
      y_l_nxt    = y_l;
      cnt_nxt    = cnt;
      come_nxt   = 1'b0;
      inv_nxt    = 1'b0;
      glitch_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (armed && hit_s && !hit_s_d && !game_set_i) begin
               x_l_nxt   = x_s;
               y_l_nxt   = y_s;
               cnt_nxt   = '0;
               state_nxt = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (game_set_i) begin
               state_nxt = IDLE;
            end else if (!hit_s) begin
               glitch_nxt = 1'b1;
               state_nxt  = IDLE;
            end else if (x_s != x_l || y_s != y_l) begin
               x_l_nxt = x_s;
               y_l_nxt = y_s;
               cnt_nxt = '0;
            end else if (cnt == DB_LAST) begin
               // The result pulse is registered on entry to EMIT, so it is
               // high for exactly the cycle the FSM spends in EMIT.
               come_nxt  = coord_ok;
               inv_nxt   = ~coord_ok;
               state_nxt = EMIT;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         EMIT: begin
            cnt_nxt   = '0;
            state_nxt = LOCKOUT;
         end
         LOCKOUT: begin
            if (cnt < LO_LAST)
               cnt_nxt = cnt + 1'b1;
            else if (!hit_s)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         x_l               <= '0;
         y_l               <= '0;
         cnt               <= '0;
         dart_come_o       <= 1'b0;
         invalid_o         <= 1'b0;
         glitch_o          <= 1'b0;
         busy_o            <= 1'b0;
         dart_position_x_o <= '0;
         dart_position_y_o <= '0;
         dart_count_o      <= '0;
      end else begin
         state       <= state_nxt;
         x_l         <= x_l_nxt;
         y_l         <= y_l_nxt;
         cnt         <= cnt_nxt;
         dart_come_o <= come_nxt;
         invalid_o   <= inv_nxt;
         glitch_o    <= glitch_nxt;
         busy_o      <= (state_nxt != IDLE);
         if (come_nxt) begin
            dart_position_x_o <= x_l;
            dart_position_y_o <= y_l;
         end
         if (game_set_i)
            dart_count_o <= '0;
         else if (come_nxt)
            dart_count_o <= dart_count_o + 1'b1;
      end
   end

endmodule
